// File: rtl/pixie_dma_responder_if.sv
// CPU/memory/video signal bundle for the Pixie DMA responder.
// DMA_IN_EN adds the DMA-in request, write data and memory write strobe.
interface pixie_dma_responder_if;
    logic        clk_enable;
    logic        dmao;
    logic        int_req;
    logic        r0_load;
    logic [15:0] r0_din;
    logic        ie_set;
    logic        ie_clr;
    logic [7:0]  mem_data;
    logic [1:0]  sc;
    logic        cpu_hold;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  dma_data;
    logic        dma_strobe;
    logic        int_ack;
    logic [15:0] r0;
    logic        ie;
`ifdef DMA_IN_EN
    logic        dmai;
    logic [7:0]  dma_wdata;
    logic        mem_wr;
`endif

    // System side: drives requests and CPU controls, observes the responder.
    modport master (
`ifdef DMA_IN_EN
        output dmai, output dma_wdata, input mem_wr,
`endif
        output clk_enable, output dmao, output int_req, output r0_load,
        output r0_din, output ie_set, output ie_clr, output mem_data,
        input  sc, input cpu_hold, input mem_addr, input mem_rd,
        input  dma_data, input dma_strobe, input int_ack, input r0, input ie
    );

    modport slave (
`ifdef DMA_IN_EN
        input dmai, input dma_wdata, output mem_wr,
`endif
        input  clk_enable, input dmao, input int_req, input r0_load,
        input  r0_din, input ie_set, input ie_clr, input mem_data,
        output sc, output cpu_hold, output mem_addr, output mem_rd,
        output dma_data, output dma_strobe, output int_ack, output r0, output ie
    );
endinterface

// File: rtl/pixie_dma_responder.sv
// Steals machine cycles from the CPU for Pixie DMA-out fetches and interrupts.
// Optional DMA_IN_EN adds a DMA-in (memory write) cycle type.
module pixie_dma_responder #(
    parameter int unsigned CYCLE_PHASES = 8,
    parameter logic [15:0] R0_RESET     = 16'h0000
) (
    input logic              clk,
    input logic              reset_n,
    pixie_dma_responder_if.slave bus
);

    localparam int unsigned PH_W = $clog2(CYCLE_PHASES);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(CYCLE_PHASES - 1);
    localparam logic [PH_W-1:0] PH_STROBE  = PH_W'(CYCLE_PHASES - 3);
    localparam logic [PH_W-1:0] PH_XFER_HI = PH_W'(CYCLE_PHASES - 2);
    localparam logic [PH_W-1:0] PH_XFER_LO = PH_W'(1);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_DMA,
`ifdef DMA_IN_EN
        ST_DMAIN,
`endif
        ST_INT
    } state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [1:0]      sc_q, sc_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic [15:0]     mem_addr_q, mem_addr_d;
    logic            mem_rd_q, mem_rd_d;
    logic [7:0]      dma_data_q, dma_data_d;
    logic            dma_strobe_q, dma_strobe_d;
    logic            int_ack_q, int_ack_d;
    logic [15:0]     r0_q, r0_d;
    logic            ie_q, ie_d;
    logic            xfer_q, xfer_d;
    logic            in_window;
`ifdef DMA_IN_EN
    logic            mem_wr_q, mem_wr_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CPU;
            ph_q         <= '0;
            sc_q         <= 2'b00;
            cpu_hold_q   <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_rd_q     <= 1'b0;
            dma_data_q   <= 8'h00;
            dma_strobe_q <= 1'b0;
            int_ack_q    <= 1'b0;
            r0_q         <= R0_RESET;
            ie_q         <= 1'b1;
`ifdef DMA_IN_EN
            mem_wr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            sc_q         <= sc_d;
            cpu_hold_q   <= cpu_hold_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            dma_data_q   <= dma_data_d;
            dma_strobe_q <= dma_strobe_d;
            int_ack_q    <= int_ack_d;
            r0_q         <= r0_d;
            ie_q         <= ie_d;
`ifdef DMA_IN_EN
            mem_wr_q     <= mem_wr_d;
`endif
        end
    end

`ifdef DMA_IN_EN
    assign xfer_q = (state_q == ST_DMA) || (state_q == ST_DMAIN);
`else
    assign xfer_q = (state_q == ST_DMA);
`endif

    // Phase advance, boundary decision and register updates; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        r0_d         = r0_q;
        ie_d         = ie_q;
        dma_data_d   = dma_data_q;
        dma_strobe_d = 1'b0;
        int_ack_d    = 1'b0;
        sc_d         = 2'b00;
        cpu_hold_d   = 1'b0;
        xfer_d       = 1'b0;

        if (bus.clk_enable) begin
            ph_d = ph_q + PH_W'(1);
            if (state_q == ST_CPU) begin
                if (bus.r0_load) r0_d = bus.r0_din;
                if (bus.ie_clr) ie_d = 1'b0;
                else if (bus.ie_set) ie_d = 1'b1;
            end
            if ((state_q == ST_DMA) && (ph_q == PH_STROBE)) begin
                dma_data_d   = bus.mem_data;
                dma_strobe_d = 1'b1;
            end
            if (ph_q == PH_LAST) begin
                if (xfer_q) r0_d = r0_q + 16'd1;
                if (!bus.dmao) begin
                    state_d = ST_DMA;
                end
`ifdef DMA_IN_EN
                else if (!bus.dmai) begin
                    state_d = ST_DMAIN;
                end
`endif
                else if (bus.int_req && ie_q) begin
                    state_d   = ST_INT;
                    ie_d      = 1'b0;
                    int_ack_d = 1'b1;
                end else begin
                    state_d = ST_CPU;
                end
            end
        end

        case (state_d)
            ST_DMA: begin
                sc_d       = 2'b10;
                cpu_hold_d = 1'b1;
                xfer_d     = 1'b1;
            end
`ifdef DMA_IN_EN
            ST_DMAIN: begin
                sc_d       = 2'b10;
                cpu_hold_d = 1'b1;
                xfer_d     = 1'b1;
            end
`endif
            ST_INT: begin
                sc_d       = 2'b11;
                cpu_hold_d = 1'b1;
            end
            default: begin
                sc_d       = 2'b00;
                cpu_hold_d = 1'b0;
            end
        endcase
    end

    // Bus strobes are confined to the inner phases of a transfer cycle.
    assign in_window  = (ph_d >= PH_XFER_LO) && (ph_d <= PH_XFER_HI);
    assign mem_addr_d = xfer_d ? r0_d : mem_addr_q;
    assign mem_rd_d   = (state_d == ST_DMA) && in_window;
`ifdef DMA_IN_EN
    assign mem_wr_d   = (state_d == ST_DMAIN) && in_window;
    assign bus.mem_wr = mem_wr_q;
`endif

    assign bus.sc         = sc_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.dma_data   = dma_data_q;
    assign bus.dma_strobe = dma_strobe_q;
    assign bus.int_ack    = int_ack_q;
    assign bus.r0         = r0_q;
    assign bus.ie         = ie_q;

endmodule

// File: tb/tb_pixie_dma_responder.sv
// Self-checking bench for pixie_dma_responder: machine-cycle reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
module tb_pixie_dma_responder;

    localparam int CP    = 8;
    localparam int M_CPU = 0;
    localparam int M_DMA = 1;
    localparam int M_INT = 2;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] key     = 8'h00;

    pixie_dma_responder_if bus ();

    pixie_dma_responder #(
        .CYCLE_PHASES(CP),
        .R0_RESET    (16'h0000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Memory returns the address low byte, optionally scrambled by key.
    assign bus.mem_data = bus.mem_addr[7:0] ^ key;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, in machine-cycle terms.
    int          m_ph;
    int          m_mode;
    logic [15:0] m_r0;
    logic [15:0] m_addr;
    logic        m_ie;
    logic [7:0]  m_data;
    logic        m_strobe;
    logic        m_ack;

    logic [7:0]  got_data[$];
    int          ack_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph     = 0;
        m_mode   = M_CPU;
        m_r0     = 16'h0000;
        m_addr   = 16'h0000;
        m_ie     = 1'b1;
        m_data   = 8'h00;
        m_strobe = 1'b0;
        m_ack    = 1'b0;
    endtask

    task automatic model_step();
        logic ie_old;
        ie_old   = m_ie;
        m_strobe = 1'b0;
        m_ack    = 1'b0;
        if (bus.clk_enable) begin
            if (m_mode == M_CPU) begin
                if (bus.r0_load) m_r0 = bus.r0_din;
                if (bus.ie_clr) m_ie = 1'b0;
                else if (bus.ie_set) m_ie = 1'b1;
            end
            if (m_mode == M_DMA && m_ph == CP - 3) begin
                m_data   = m_addr[7:0] ^ key;
                m_strobe = 1'b1;
            end
            if (m_ph == CP - 1) begin
                if (m_mode == M_DMA) m_r0 = m_r0 + 16'd1;
                if (!bus.dmao) m_mode = M_DMA;
                else if (bus.int_req && ie_old) begin
                    m_mode = M_INT;
                    m_ie   = 1'b0;
                    m_ack  = 1'b1;
                end else m_mode = M_CPU;
            end
            m_ph = (m_ph + 1) % CP;
        end
        if (m_mode == M_DMA) m_addr = m_r0;
    endtask

    task automatic compare();
        logic [1:0] esc;
        logic       erd;
        esc = (m_mode == M_DMA) ? 2'b10 : (m_mode == M_INT) ? 2'b11 : 2'b00;
        erd = (m_mode == M_DMA) && (m_ph >= 1) && (m_ph <= CP - 2);
        check("sc",         16'(bus.sc),         16'(esc));
        check("cpu_hold",   16'(bus.cpu_hold),   16'(m_mode != M_CPU));
        check("mem_addr",   bus.mem_addr,        m_addr);
        check("mem_rd",     16'(bus.mem_rd),     16'(erd));
        check("dma_data",   16'(bus.dma_data),   16'(m_data));
        check("dma_strobe", 16'(bus.dma_strobe), 16'(m_strobe));
        check("int_ack",    16'(bus.int_ack),    16'(m_ack));
        check("r0",         bus.r0,              m_r0);
        check("ie",         16'(bus.ie),         16'(m_ie));
        if (bus.dma_strobe === 1'b1) got_data.push_back(bus.dma_data);
        if (bus.int_ack === 1'b1) ack_cnt++;
    endtask

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        if (reset_n) model_step();
        #1;
        compare();
    end

    task automatic load_r0(input logic [15:0] v);
        @(negedge clk);
        bus.r0_load = 1'b1;
        bus.r0_din  = v;
        @(negedge clk);
        bus.r0_load = 1'b0;
    endtask

    task automatic wait_sc(input logic [1:0] v, input string nm);
        for (int i = 0; i < 200 && bus.sc !== v; i++) @(negedge clk);
        check(nm, 16'(bus.sc), 16'(v));
    endtask

    task automatic wait_strobes(input int n, input string nm);
        for (int i = 0; i < 400 && got_data.size() < n; i++) @(negedge clk);
        check(nm, 16'(got_data.size()), 16'(n));
    endtask

    task automatic wait_ack(input string nm);
        for (int i = 0; i < 4 * CP && ack_cnt == 0; i++) @(negedge clk);
        check(nm, 16'(ack_cnt), 16'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gaps;
        bit started;
        model_reset();
        got_data.delete();
        ack_cnt        = 0;
        bus.clk_enable = 1'b0;
        bus.dmao       = 1'b1;
        bus.int_req    = 1'b0;
        bus.r0_load    = 1'b0;
        bus.r0_din     = 16'h0000;
        bus.ie_set     = 1'b0;
        bus.ie_clr     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r0", bus.r0, 16'h0000);
        check("rst_ie", 16'(bus.ie), 16'd1);
        check("rst_sc", 16'(bus.sc), 16'd0);
        reset_n        = 1'b1;
        bus.clk_enable = 1'b1;
        repeat (4) @(negedge clk);

        // Eight-cycle line burst from 0x0900.
        load_r0(16'h0900);
        got_data.delete();
        bus.dmao = 1'b0;
        gaps     = 0;
        started  = 1'b0;
        for (int i = 0; i < 400 && got_data.size() < 8; i++) begin
            @(negedge clk);
            if (bus.sc == 2'b10) started = 1'b1;
            if (started && !bus.cpu_hold) gaps++;
        end
        bus.dmao = 1'b1;
        check("burst_count", 16'(got_data.size()), 16'd8);
        for (int k = 0; k < got_data.size() && k < 8; k++)
            check("burst_data", 16'(got_data[k]), 16'(k));
        check("burst_hold_gaps", 16'(gaps), 16'd0);
        repeat (12) @(negedge clk);
        check("burst_r0_end", bus.r0, 16'h0908);
        check("burst_back_cpu", 16'(bus.sc), 16'd0);

        // Pointer wrap.
        load_r0(16'hFFFF);
        got_data.delete();
        bus.dmao = 1'b0;
        wait_strobes(1, "wrap_strobe");
        bus.dmao = 1'b1;
        repeat (12) @(negedge clk);
        check("wrap_r0", bus.r0, 16'h0000);

        // DMA outranks a simultaneous interrupt.
        got_data.delete();
        ack_cnt     = 0;
        bus.dmao    = 1'b0;
        bus.int_req = 1'b1;
        wait_strobes(1, "prio_strobe");
        check("prio_dma_first", 16'(bus.sc), 16'h0002);
        check("prio_no_ack_yet", 16'(ack_cnt), 16'd0);
        bus.dmao = 1'b1;
        wait_ack("prio_int_ack");
        check("prio_int_sc", 16'(bus.sc), 16'h0003);
        bus.int_req = 1'b0;
        repeat (10) @(negedge clk);
        check("prio_ie_cleared", 16'(bus.ie), 16'd0);

        // Masked interrupt, then unmasked by ie_set.
        ack_cnt     = 0;
        bus.int_req = 1'b1;
        repeat (3 * CP) @(negedge clk);
        check("masked_no_int", 16'(ack_cnt), 16'd0);
        bus.ie_set = 1'b1;
        @(negedge clk);
        bus.ie_set = 1'b0;
        check("ie_set_applied", 16'(bus.ie), 16'd1);
        wait_ack("int_after_ie_set");
        bus.int_req = 1'b0;
        repeat (10) @(negedge clk);

        // r0_load ignored in DMA, accepted in CPU.
        load_r0(16'h0500);
        bus.dmao = 1'b0;
        wait_sc(2'b10, "load_dma_enter");
        @(negedge clk);
        bus.r0_load = 1'b1;
        bus.r0_din  = 16'h1234;
        @(negedge clk);
        bus.r0_load = 1'b0;
        bus.dmao    = 1'b1;
        check("load_in_dma_ignored", bus.r0, 16'h0500);
        repeat (12) @(negedge clk);
        check("load_dma_inc", bus.r0, 16'h0501);
        load_r0(16'h1234);
        check("load_in_cpu", bus.r0, 16'h1234);

        // Asynchronous reset four phases into a DMA cycle.
        bus.dmao = 1'b0;
        wait_sc(2'b10, "rst_dma_enter");
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_sc",       16'(bus.sc),         16'd0);
        check("mid_rst_hold",     16'(bus.cpu_hold),   16'd0);
        check("mid_rst_addr",     bus.mem_addr,        16'h0000);
        check("mid_rst_rd",       16'(bus.mem_rd),     16'd0);
        check("mid_rst_data",     16'(bus.dma_data),   16'd0);
        check("mid_rst_strobe",   16'(bus.dma_strobe), 16'd0);
        check("mid_rst_ack",      16'(bus.int_ack),    16'd0);
        check("mid_rst_r0",       bus.r0,              16'h0000);
        check("mid_rst_ie",       16'(bus.ie),         16'd1);
        bus.dmao = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized soak with gated clk_enable.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.clk_enable = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) bus.dmao = ~bus.dmao;
            if ($urandom % 12 == 0) bus.int_req = ~bus.int_req;
            bus.r0_load = ($urandom % 20) == 0;
            bus.r0_din  = 16'($urandom);
            bus.ie_set  = ($urandom % 25) == 0;
            bus.ie_clr  = ($urandom % 30) == 0;
            if ($urandom % 50 == 0) key = 8'($urandom);
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixie_dma_responder.md
# pixie_dma_responder

CPU-side responder for the Pixie video generator's DMA-out and interrupt requests. It sits between the CPU core, system memory and the video block. It samples the active-low DMAO and active-high INT requests at machine-cycle boundaries. It then steals S2 (DMA) or S3 (interrupt) machine cycles from the CPU, fetching display bytes from memory at R0 and handing them to the video block's data input.

## Interface
Parameters:
- CYCLE_PHASES, 8: clk_enable ticks per machine cycle; must be a power of two.
- R0_RESET, 16'h0000: reset value of the DMA pointer R0.

Ports (one clock, `clk`; reset is asynchronous and active-low, `reset_n`):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_enable  in  1  machine-phase tick
- dmao  in  1  DMA-out request from video block, active low
- int_req  in  1  interrupt request, active high
- r0_load  in  1  CPU write strobe for R0
- r0_din  in  16  CPU write data for R0
- ie_set, ie_clr  in  1  CPU interrupt-enable control (RET / DIS)
- mem_data  in  8  memory read data
- sc  out  2  state code of current machine cycle (00 fetch/exec, 10 DMA, 11 INT)
- cpu_hold  out  1  CPU must stall for this machine cycle
- mem_addr  out  16  memory address during owned cycles
- mem_rd  out  1  memory read enable
- dma_data  out  8  byte delivered to video block
- dma_strobe  out  1  one-clk pulse when dma_data updates
- int_ack  out  1  one-clk pulse at start of S3 cycle
- r0  out  16  current DMA pointer
- ie  out  1  interrupt enable

## Operation
- Phase counter `ph` counts 0..CYCLE_PHASES-1 on clk_enable and wraps. Each wrap ends one machine cycle.
- State machine: CPU, DMA, INT. Next state is decided on the clk_enable tick with `ph` = last:
  - dmao==0 → DMA;
  - else int_req && ie → INT;
  - else CPU.
- DMA always has priority over INT. A pending INT is re-evaluated at each boundary.
- CPU state: sc=00, cpu_hold=0, mem_rd=0, mem_addr holds its last value.
- DMA state: sc=10, cpu_hold=1, mem_addr=r0.
  - mem_rd=1 for ph 1..CYCLE_PHASES-2.
  - On the tick at ph=CYCLE_PHASES-3, dma_data<=mem_data and dma_strobe pulses.
  - At the cycle-end tick, r0<=r0+1, wrapping 16'hFFFF→16'h0000.
- INT state: sc=11, cpu_hold=1, mem_rd=0.
  - int_ack pulses on the first clk of the cycle.
  - ie<=0 on entry.
- Back-to-back DMA: dmao still low at the DMA cycle end starts another DMA cycle with no CPU cycle between. This supports 8-byte line bursts.
- r0_load is accepted on a clk_enable tick only in CPU state. It is ignored in DMA and INT states.
- ie_set and ie_clr are honoured only in CPU state; ie_clr wins if both are asserted. INT entry overrides both.

## Timing
- Reset (async, immediate, including mid-cycle): ph=0, state=CPU, sc=00, cpu_hold=0, mem_addr=0, mem_rd=0, dma_data=0, dma_strobe=0, int_ack=0, r0=R0_RESET, ie=1.
- All outputs are registered.
- sc, cpu_hold and mem_addr change on the clk after the boundary tick.
- Request-to-cycle latency is at most CYCLE_PHASES ticks. A request must be held through the boundary tick to be seen.
- Request-to-data latency: dma_strobe occurs CYCLE_PHASES-3 ticks into the DMA cycle.
- clk_enable low freezes ph, state and all strobes. Pulses never exceed 1 clk.
- A dmao deassertion mid-DMA-cycle does not abort the cycle.

## Configuration
- DMA_IN_EN defined:
  - adds ports dmai (in, active low), dma_wdata (in, 8) and mem_wr (out).
  - Adds state DMAIN, with priority DMAOUT > DMAIN > INT and sc=10.
  - DMAIN asserts mem_wr for ph 1..CYCLE_PHASES-2 at mem_addr=r0, writes dma_wdata, and increments r0 identically to DMA out.
- DMA_IN_EN undefined: ports and state are absent; only DMA-out and INT exist.

## Test plan
- Reset mid-DMA at ph=4: all outputs go to reset values the same clk; r0=R0_RESET; ie=1.
- dmao low for 8 boundaries with r0=16'h0900 and memory = address low byte:
  - 8 consecutive DMA cycles;
  - dma_data sequence 00..07;
  - r0 ends at 16'h0908;
  - cpu_hold stays 1 throughout.
- r0=16'hFFFF and one DMA cycle → r0 = 16'h0000.
- dmao low and int_req high together with ie=1: DMA cycle first, then an INT cycle with int_ack pulse; ie becomes 0.
- int_req high with ie=0: no INT cycle. After ie_set in a CPU cycle, an INT occurs at the next boundary.
- r0_load of 16'h1234 during a DMA cycle is ignored. The same load during a CPU cycle gives r0=16'h1234.
